// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Phase and error-code encodings shared by the traffic light monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_RED     = 3'd1,
    PH_RED_YEL = 3'd2,
    PH_GREEN   = 3'd3,
    PH_YEL     = 3'd4
  } phase_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ILLEGAL = 3'd1,
    ERR_BAD_SEQ = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_LONG    = 3'd4
  } err_code_t;

  function automatic phase_t next_legal(input phase_t p);
    case (p)
      PH_RED:     next_legal = PH_RED_YEL;
      PH_RED_YEL: next_legal = PH_GREEN;
      PH_GREEN:   next_legal = PH_YEL;
      default:    next_legal = PH_RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_dwell_timer.sv
// ============================================================================
// Module   : tl_dwell_timer
// Purpose  : Restartable saturating dwell counter with SHORT/LONG dwell checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tl_dwell_timer #(
  parameter int DW  = 5,
  parameter int TOL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        check_en,
  input  logic [31:0] expected,
  output logic        short_hit,
  output logic        long_hit
);

  localparam logic [31:0] C_TOL = 32'(TOL);

  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_inc;
  logic          long_flag;
  logic [31:0]   lo_limit;
  logic [31:0]   hi_limit;

  assign dwell_inc = (&dwell) ? dwell : dwell + 1'b1;
  assign lo_limit  = (expected > C_TOL) ? expected - C_TOL : 32'd0;
  assign hi_limit  = expected + C_TOL + 32'd1;

  // SHORT is judged on the departing phase's final dwell; LONG on the held phase.
  assign short_hit = check_en && restart && !long_flag && (32'(dwell) < lo_limit);
  assign long_hit  = check_en && !restart && !long_flag && (32'(dwell_inc) == hi_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      long_flag <= 1'b0;
    end else if (restart) begin
      dwell     <= DW'(1);
      long_flag <= 1'b0;
    end else begin
      dwell <= dwell_inc;
      if (long_hit) long_flag <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Checks light combinations, phase order and phase dwell of a
//            one-way traffic light; reports coded error pulses and a count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES    = 30,
  parameter int GREEN_CYCLES  = 30,
  parameter int YELLOW_CYCLES = 3,
  parameter int TOL           = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [2:0] phase,
  output logic       err_valid,
  output logic [2:0] err_code,
  output logic [7:0] err_count,
  output logic       in_sync
);

  localparam int MAX_CYCLES = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int DW         = $clog2(MAX_CYCLES + TOL + 2);

  logic [2:0]  lights_q;
  phase_t      phase_q, phase_d, dec;
  logic        legal, change, bad_seq, enter_red;
  logic        short_hit, long_hit, seq_armed;
  err_code_t   code_d;
  logic [31:0] expected;

  always_ff @(posedge clk) begin
    if (rst) lights_q <= 3'b000;
    else     lights_q <= {red, yellow, green};
  end

  always_comb begin
    legal = 1'b1;
    dec   = phase_q;
    case (lights_q)
      3'b000:  dec = PH_OFF;
      3'b100:  dec = PH_RED;
      3'b110:  dec = PH_RED_YEL;
      3'b001:  dec = PH_GREEN;
      3'b010:  dec = PH_YEL;
      default: legal = 1'b0;
    endcase
  end

  assign change    = legal && (dec != phase_q);
  assign bad_seq   = change && (dec != next_legal(phase_q));
  assign enter_red = change && (dec == PH_RED);

  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH_OFF;
    else     phase_q <= phase_d;
  end

  // Illegal combinations leave the phase untouched; bad sequences still resync.
  always_comb begin
    phase_d = phase_q;
    if (legal) phase_d = dec;
  end

  always_comb begin
    code_d = ERR_NONE;
    if (!legal)         code_d = ERR_ILLEGAL;
    else if (bad_seq)   code_d = ERR_BAD_SEQ;
    else if (short_hit) code_d = ERR_SHORT;
    else if (long_hit)  code_d = ERR_LONG;
  end

  always_comb begin
    expected = 32'd0;
    case (phase_q)
      PH_RED:             expected = 32'(RED_CYCLES);
      PH_GREEN:           expected = 32'(GREEN_CYCLES);
      PH_RED_YEL, PH_YEL: expected = 32'(YELLOW_CYCLES);
      default:            expected = 32'd0;
    endcase
  end

  tl_dwell_timer #(
    .DW  (DW),
    .TOL (TOL)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .restart   (change),
    .check_en  (phase_q != PH_OFF),
    .expected  (expected),
    .short_hit (short_hit),
    .long_hit  (long_hit)
  );

  // seq_armed marks an error-free run since the last clean RED entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= 8'd0;
      in_sync   <= 1'b0;
      seq_armed <= 1'b0;
    end else begin
      err_valid <= (code_d != ERR_NONE);
      err_code  <= code_d;
      if (code_d != ERR_NONE) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        in_sync   <= 1'b0;
        seq_armed <= 1'b0;
      end else if (enter_red) begin
        if (phase_q == PH_YEL && seq_armed) in_sync <= 1'b1;
        seq_armed <= 1'b1;
      end
    end
  end

  assign phase = phase_q;

endmodule

`default_nettype wire
